iro_freq_meter: RTL and testbench

Parametrised successor to the instrumented ring oscillator. It contains a ring with a selectable odd number of inverting stages and exposes every stage tap. It adds a clk-domain measurement engine that opens a gate of a programmed number of clk cycles and counts oscillator rising edges through a synchronised request/acknowledge handshake. The result comes back as a saturating count with overflow and stuck-ring flags, so that firmware can characterise ring frequency against stage count.

---
 rtl/iro_freq_meter.sv | 127 ++++++++++++
 tb/tb_iro_freq_meter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iro_freq_meter.sv
// iro_freq_meter: selectable-length ring oscillator with a gated, handshaked edge-count frequency meter.
// Define IRO_PHASE_SNAPSHOT_EN to add the synchronised phase snapshot on snap (tied to 0 otherwise).
`timescale 1ns/1ps
module iro_freq_meter #(
    parameter int MAX_STAGES  = 16,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 12,
    parameter int STAGE_DELAY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            start,
    input  logic [$clog2(MAX_STAGES/2)-1:0] n_sel,
    input  logic [GATE_W-1:0]               gate_cycles,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_W-1:0]                count,
    output logic                            overflow,
    output logic                            stuck,
    output logic [MAX_STAGES-1:0]           phases,
    output logic [MAX_STAGES-1:0]           snap
);
    localparam int SEL_W = $clog2(MAX_STAGES/2);
    localparam int TMR_W = GATE_W > 7 ? GATE_W : 7;
    typedef enum logic [2:0] {IDLE, ARM, GATE, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [SEL_W-1:0] n_sel_q;
    logic [GATE_W-1:0] gate_q;
    logic [TMR_W-1:0] timer;
    logic ack_seen, ring_clr, gate_req, ring_en, fb, ack, gate_last, timeout;
    logic [1:0] gate_sync, ack_sync;
    logic [CNT_W-1:0] edges;
    logic [MAX_STAGES-1:0] tap, stage_in;

    assign ring_en = enable & (state inside {ARM, GATE, DRAIN});
    assign fb = tap[{n_sel_q, 1'b0}];
    assign stage_in = {~tap[MAX_STAGES-2:0], ~(ring_en & fb)};
`ifdef SYNTHESIS
    assign tap = stage_in;
`else
    assign #(STAGE_DELAY) tap = stage_in;
`endif
    assign phases = tap;

    // Oscillator domain: only meaningful while ring_clr is low.
    always_ff @(posedge tap[0] or posedge ring_clr) begin
        if (ring_clr) begin
            gate_sync <= '0;
            edges <= '0;
        end else begin
            gate_sync <= {gate_sync[0], gate_req};
            if (gate_sync[1] && edges != '1) edges <= edges + 1'b1;
        end
    end

    always_ff @(posedge clk) ack_sync <= rst ? 2'b00 : {ack_sync[0], gate_sync[1]};
    assign ack = ack_sync[1];

    assign gate_last = timer == TMR_W'(gate_q) - 1'b1;
    assign timeout = timer == TMR_W'(63);
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? ARM : IDLE;
            ARM:     state_n = gate_q == '0 ? DRAIN : timer == TMR_W'(3) ? GATE : ARM;
            GATE:    state_n = gate_last ? DRAIN : GATE;
            DRAIN:   state_n = (!ack || timeout) ? DONE : DRAIN;
            DONE:    state_n = start ? ARM : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ring_clr also covers DONE so a back-to-back run starts from a zeroed counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ring_clr <= 1'b1;
            gate_req <= 1'b0;
            timer <= '0;
            ack_seen <= 1'b0;
            n_sel_q <= '0;
            gate_q <= '0;
            count <= '0;
            overflow <= 1'b0;
            stuck <= 1'b0;
        end else begin
            state <= state_n;
            ring_clr <= state_n inside {IDLE, DONE};
            gate_req <= state_n == GATE;
            timer <= state_n != state ? '0 : timer + 1'b1;
            if (state inside {IDLE, DONE} && start) begin
                n_sel_q <= n_sel;
                gate_q <= gate_cycles;
                ack_seen <= 1'b0;
            end
            if (state == GATE && ack) ack_seen <= 1'b1;
            if (state == DRAIN && state_n == DONE) begin
                count <= ack ? '0 : edges;
                overflow <= !ack && edges == '1;
                stuck <= !ack_seen || ack;
            end
        end
    end

`ifdef IRO_PHASE_SNAPSHOT_EN
    logic [MAX_STAGES-1:0] snap_s1, snap_s2, snap_cap;
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_s1 <= '0;
            snap_s2 <= '0;
            snap_cap <= '0;
            snap <= '0;
        end else begin
            snap_s1 <= tap;
            snap_s2 <= snap_s1;
            if (state == GATE && gate_last) snap_cap <= snap_s2;
            if (state == DRAIN && state_n == DONE) snap <= snap_cap;
        end
    end
`else
    assign snap = '0;
`endif
endmodule

// File: tb/tb_iro_freq_meter.sv
// tb_iro_freq_meter: directed, table-driven bench for the ring-oscillator frequency meter.
`timescale 1ns/1ps
module tb_iro_freq_meter;
    logic clk = 0, rst = 1, enable = 0, start = 0, start8 = 0;
    logic [2:0] n_sel = 0;
    logic [11:0] gate_cycles = 0;
    logic busy, done, overflow, stuck, busy8, done8, overflow8, stuck8;
    logic [15:0] count, phases, snap, phases8, snap8;
    logic [7:0] count8;
    int cyc = 0, errors = 0, checks = 0;

    typedef struct { int n, g, e, cnt_lo, cnt_hi, ovf, stk, lat_lo, lat_hi; } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iro_freq_meter dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .n_sel(n_sel),
        .gate_cycles(gate_cycles), .busy(busy), .done(done), .count(count),
        .overflow(overflow), .stuck(stuck), .phases(phases), .snap(snap)
    );

    iro_freq_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .enable(1'b1), .start(start8), .n_sel(3'd0),
        .gate_cycles(12'd200), .busy(busy8), .done(done8), .count(count8),
        .overflow(overflow8), .stuck(stuck8), .phases(phases8), .snap(snap8)
    );

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            if (done) got = 1;
            else @(negedge clk);
        end
        chk(name, int'(got), 1, 1);
    endtask

    task automatic measure(input int n, input int g, input int e, output int lat);
        int t0;
        @(negedge clk);
        n_sel = 3'(n);
        gate_cycles = 12'(g);
        enable = e[0];
        start = 1;
        @(negedge clk);
        t0 = cyc;
        start = 0;
        wait_done("done_seen");
        lat = cyc - t0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, t0;
        bit got;
        vecs[0] = '{0, 100, 1, 498, 502, 0, 0, 105, 112};
        vecs[1] = '{2, 100, 1,  98, 102, 0, 0, 105, 112};
        vecs[2] = '{1, 100, 1, 165, 169, 0, 0, 105, 112};
        vecs[3] = '{3,  50, 1,  34,  38, 0, 0,  55,  62};
        vecs[4] = '{7, 100, 1,  31,  35, 0, 0, 105, 115};
        vecs[5] = '{0,   0, 1,   0,   0, 0, 1,   2,   2};
        vecs[6] = '{0,  10, 0,   0,   0, 0, 1,  15,  15};

        start = 1;
        repeat (4) @(negedge clk);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_count", int'(count), 0, 0);
        chk("rst_overflow", int'(overflow), 0, 0);
        chk("rst_stuck", int'(stuck), 0, 0);
        chk("rst_snap", int'(snap), 0, 0);
        rst = 0;
        start = 0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            measure(vecs[i].n, vecs[i].g, vecs[i].e, lat);
            chk($sformatf("v%0d_count", i), int'(count), vecs[i].cnt_lo, vecs[i].cnt_hi);
            chk($sformatf("v%0d_overflow", i), int'(overflow), vecs[i].ovf, vecs[i].ovf);
            chk($sformatf("v%0d_stuck", i), int'(stuck), vecs[i].stk, vecs[i].stk);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat_lo, vecs[i].lat_hi);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), int'(done), 0, 0);
            chk($sformatf("v%0d_busy_fall", i), int'(busy), 0, 0);
        end

        // Ring stopped mid-gate: ack stays high and DRAIN must time out.
        @(negedge clk);
        enable = 1; n_sel = 0; gate_cycles = 100; start = 1;
        @(negedge clk);
        t0 = cyc;
        start = 0;
        repeat (20) @(negedge clk);
        enable = 0;
        wait_done("to_done");
        chk("to_latency", cyc - t0, 168, 168);
        chk("to_count", int'(count), 0, 0);
        chk("to_overflow", int'(overflow), 0, 0);
        chk("to_stuck", int'(stuck), 1, 1);
        @(negedge clk);

        // Back-to-back with start held; config changes while busy must be ignored.
        enable = 1; n_sel = 2; gate_cycles = 100; start = 1;
        @(negedge clk);
        n_sel = 1;
        gate_cycles = 7;
        repeat (30) @(negedge clk);
        gate_cycles = 100;
        wait_done("b2b_done1");
        chk("b2b_count1", int'(count), 98, 102);
        chk("b2b_stuck1", int'(stuck), 0, 0);
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        chk("b2b_busy_held", int'(busy), 1, 1);
        chk("b2b_done_pulse", int'(done), 0, 0);
        wait_done("b2b_done2");
        chk("b2b_count2", int'(count), 165, 169);
        chk("b2b_overflow2", int'(overflow), 0, 0);
        chk("b2b_stuck2", int'(stuck), 0, 0);
`ifdef IRO_PHASE_SNAPSHOT_EN
        chk("snap_nonzero", int'(snap != 16'h0), 1, 1);
`else
        chk("snap_zero", int'(snap), 0, 0);
`endif
        @(negedge clk);

        // Saturating counter on the narrow instance.
        start8 = 1;
        @(negedge clk);
        start8 = 0;
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            if (done8) got = 1;
            else @(negedge clk);
        end
        chk("c8_done_seen", int'(got), 1, 1);
        chk("c8_count", int'(count8), 255, 255);
        chk("c8_overflow", int'(overflow8), 1, 1);
        chk("c8_stuck", int'(stuck8), 0, 0);

        // Reset mid-GATE with start held, then a clean re-measurement.
        @(negedge clk);
        enable = 1; n_sel = 0; gate_cycles = 100; start = 1;
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        rst = 1;
        start = 1;
        @(negedge clk);
        chk("mr_busy", int'(busy), 0, 0);
        chk("mr_count", int'(count), 0, 0);
        chk("mr_done", int'(done), 0, 0);
        repeat (3) @(negedge clk);
        chk("mr_phases", int'(phases), 16'h5555, 16'h5555);
        chk("mr_busy_start_held", int'(busy), 0, 0);
        chk("mr_snap", int'(snap), 0, 0);
        rst = 0;
        @(negedge clk);
        chk("mr_first_busy", int'(busy), 1, 1);
        start = 0;
        wait_done("mr_done_seen");
        chk("mr_recount", int'(count), 498, 502);
        chk("mr_restuck", int'(stuck), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
